timer_mag: RTL and testbench

- Microwave cook timer: the producer of timer_done, which the magnetron control logic consumes.
- Holds an MM:SS time as four BCD digits, loaded by keypad digit entry.
- Counts down once per second while the magnetron is on (mag_on from the magnetron S/R latch).
- Asserts timer_done at 00:00 so the magnetron control forces the magnetron off.

---
 rtl/timer_mag_pkg.sv | 15 +
 rtl/mw_bcd_dec.sv | 42 ++++
 rtl/timer_mag.sv | 167 ++++++++++++++++
 tb/tb_timer_mag.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_mag_pkg.sv
// Shared types and constants for the microwave cook timer.
package timer_mag_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_NINE      = 4'd9;
  localparam logic [BCD_W-1:0] SEC_TENS_WRAP = 4'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mw_bcd_dec.sv
// Combinational one-second decrement of an MM:SS time held as four BCD digits.
// 00:00 is passed through unchanged.
module mw_bcd_dec
  import timer_mag_pkg::*;
(
  input  logic [BCD_W-1:0] min_tens_i,
  input  logic [BCD_W-1:0] min_ones_i,
  input  logic [BCD_W-1:0] sec_tens_i,
  input  logic [BCD_W-1:0] sec_ones_i,
  output logic [BCD_W-1:0] min_tens_o,
  output logic [BCD_W-1:0] min_ones_o,
  output logic [BCD_W-1:0] sec_tens_o,
  output logic [BCD_W-1:0] sec_ones_o,
  output logic             is_zero_next_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    min_tens_o = min_tens_i;
    min_ones_o = min_ones_i;
    sec_tens_o = sec_tens_i;
    sec_ones_o = sec_ones_i;
    if (sec_ones_i != '0) begin
      sec_ones_o = sec_ones_i - 4'd1;
    end else if (sec_tens_i != '0) begin
      sec_tens_o = sec_tens_i - 4'd1;
      sec_ones_o = BCD_NINE;
    end else if (min_ones_i != '0) begin
      min_ones_o = min_ones_i - 4'd1;
      sec_tens_o = SEC_TENS_WRAP;
      sec_ones_o = BCD_NINE;
    end else if (min_tens_i != '0) begin
      min_tens_o = min_tens_i - 4'd1;
      min_ones_o = BCD_NINE;
      sec_tens_o = SEC_TENS_WRAP;
      sec_ones_o = BCD_NINE;
    end
    is_zero_next_o = (min_tens_o == '0) && (min_ones_o == '0) &&
                     (sec_tens_o == '0) && (sec_ones_o == '0);
  end

endmodule

// File: rtl/timer_mag.sv
// Microwave cook timer: keypad-loaded MM:SS countdown that raises timer_done at 00:00.
// Define TIMER_MAG_BEEP_EN to add the done beep; otherwise beep is tied low.
module timer_mag
  import timer_mag_pkg::*;
#(
  parameter int TICK_DIV    = 100,
  parameter int BEEP_CYCLES = 300
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clearn,
  input  logic             key_valid,
  input  logic [BCD_W-1:0] key_digit,
  input  logic             mag_on,
  output logic [BCD_W-1:0] min_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic             timer_done,
  output logic             running,
  output logic             beep
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  state_e           state_q, state_d;
  logic [BCD_W-1:0] min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
  logic [BCD_W-1:0] min_tens_d, min_ones_d, sec_tens_d, sec_ones_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             done_q, done_d, running_q, running_d;

  logic [BCD_W-1:0] dec_min_tens, dec_min_ones, dec_sec_tens, dec_sec_ones;
  logic             dec_zero;
  logic             key_accept;

  mw_bcd_dec u_dec (
    .min_tens_i     (min_tens_q),
    .min_ones_i     (min_ones_q),
    .sec_tens_i     (sec_tens_q),
    .sec_ones_i     (sec_ones_q),
    .min_tens_o     (dec_min_tens),
    .min_ones_o     (dec_min_ones),
    .sec_tens_o     (dec_sec_tens),
    .sec_ones_o     (dec_sec_ones),
    .is_zero_next_o (dec_zero)
  );

  // Keys are locked out while the magnetron runs; non-decimal codes are dropped.
  assign key_accept = key_valid && !mag_on && (key_digit <= BCD_NINE);

  always_comb begin
    state_d    = state_q;
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    pre_d      = pre_q;
    done_d     = done_q;
    if (!clearn) begin
      state_d    = IDLE;
      min_tens_d = '0;
      min_ones_d = '0;
      sec_tens_d = '0;
      sec_ones_d = '0;
      pre_d      = '0;
      done_d     = 1'b0;
    end else if (key_accept) begin
      min_tens_d = min_ones_q;
      min_ones_d = sec_tens_q;
      sec_tens_d = sec_ones_q;
      sec_ones_d = key_digit;
      pre_d      = '0;
      done_d     = 1'b0;
      state_d    = ({min_ones_q, sec_tens_q, sec_ones_q, key_digit} != '0) ? ENTRY : IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (mag_on) begin
          // Starting with nothing entered must still shut the magnetron off.
          state_d = DONE;
          done_d  = 1'b1;
        end
        ENTRY, RUN: if (mag_on) begin
          state_d = RUN;
          if (pre_q == PRE_LAST) begin
            pre_d      = '0;
            min_tens_d = dec_min_tens;
            min_ones_d = dec_min_ones;
            sec_tens_d = dec_sec_tens;
            sec_ones_d = dec_sec_ones;
            if (dec_zero) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
    running_d = (state_d == RUN) && mag_on;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      min_tens_q <= '0;
      min_ones_q <= '0;
      sec_tens_q <= '0;
      sec_ones_q <= '0;
      pre_q      <= '0;
      done_q     <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      pre_q      <= pre_d;
      done_q     <= done_d;
      running_q  <= running_d;
    end
  end

  assign min_tens   = min_tens_q;
  assign min_ones   = min_ones_q;
  assign sec_tens   = sec_tens_q;
  assign sec_ones   = sec_ones_q;
  assign timer_done = done_q;
  assign running    = running_q;

`ifdef TIMER_MAG_BEEP_EN
  localparam int BEEP_W = $clog2(BEEP_CYCLES + 1);

  logic [BEEP_W-1:0] beep_cnt_q;
  logic              beep_q;
  logic              enter_done;

  // Clear and key entry never lead into DONE, so this only fires on expiry.
  assign enter_done = (state_d == DONE) && (state_q != DONE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beep_q     <= 1'b0;
      beep_cnt_q <= '0;
    end else if (!clearn || key_accept) begin
      beep_q     <= 1'b0;
      beep_cnt_q <= '0;
    end else if (enter_done) begin
      beep_q     <= 1'b1;
      beep_cnt_q <= BEEP_W'(BEEP_CYCLES - 1);
    end else begin
      beep_q <= (beep_cnt_q != '0);
      if (beep_cnt_q != '0) beep_cnt_q <= beep_cnt_q - BEEP_W'(1);
    end
  end

  assign beep = beep_q;
`else
  assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_timer_mag.sv
// Self-checking bench for timer_mag: directed scenarios plus randomized stimulus
// against a decimal-arithmetic reference model.
module tb_timer_mag;

  localparam int TICK = 4;
  localparam int BEEP = 5;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       clearn = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       mag_on = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       timer_done, running, beep;
  logic [15:0] disp;

  assign disp = {min_tens, min_ones, sec_tens, sec_ones};

  timer_mag #(.TICK_DIV(TICK), .BEEP_CYCLES(BEEP)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .clearn     (clearn),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .mag_on     (mag_on),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .timer_done (timer_done),
    .running    (running),
    .beep       (beep)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: time as a decimal number MMSS, mode 0 idle/1 entry/2 run/3 done.
  int m_val, m_mode, m_pre, m_beep_left;
  bit m_done, m_run;

  task automatic model_reset();
    m_val = 0; m_mode = 0; m_pre = 0; m_beep_left = 0; m_done = 0; m_run = 0;
  endtask

  task automatic model_step(input bit cl, input bit kv, input int kd, input bit mg);
    int mins, secs;
    bit hit_done;
    hit_done = 0;
    if (!cl) begin
      m_val = 0; m_mode = 0; m_pre = 0; m_done = 0; m_beep_left = 0;
    end else if (kv && !mg && kd <= 9) begin
      m_val = (m_val * 10 + kd) % 10000;
      m_pre = 0; m_done = 0; m_beep_left = 0;
      m_mode = (m_val != 0) ? 1 : 0;
    end else if (mg) begin
      if (m_mode == 0) begin
        m_mode = 3; m_done = 1; hit_done = 1;
      end else if (m_mode == 1 || m_mode == 2) begin
        m_mode = 2;
        if (m_pre == TICK - 1) begin
          m_pre = 0;
          mins = m_val / 100;
          secs = m_val % 100;
          if (secs > 0) secs--;
          else if (mins > 0) begin mins--; secs = 59; end
          m_val = mins * 100 + secs;
          if (m_val == 0) begin m_mode = 3; m_done = 1; hit_done = 1; end
        end else begin
          m_pre++;
        end
      end
    end
    m_run = (m_mode == 2) && mg;
    if (hit_done) m_beep_left = BEEP;
    else if (m_beep_left > 0) m_beep_left--;
  endtask

  function automatic logic [15:0] exp_disp();
    return {4'(m_val / 1000), 4'((m_val / 100) % 10), 4'((m_val / 10) % 10), 4'(m_val % 10)};
  endfunction

  function automatic logic exp_beep();
`ifdef TIMER_MAG_BEEP_EN
    return m_beep_left > 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step(input bit cl, input bit kv, input logic [3:0] kd, input bit mg);
    clearn = cl; key_valid = kv; key_digit = kd; mag_on = mg;
    @(posedge clk);
    model_step(cl, kv, int'(kd), mg);
    #1;
  endtask

  task automatic load_time(input int v);
    for (int i = 3; i >= 0; i--) step(1, 1, 4'((v / (10 ** i)) % 10), 0);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    n_cmp++;
    if (disp !== 16'h0000) begin
      n_err++; $display("FAIL reset_disp: got %h want 0000", disp);
    end
    n_cmp++;
    if ({timer_done, running, beep} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got %b want 000", {timer_done, running, beep});
    end
    resetn = 1'b1;
  endtask

  task automatic test_entry();
    step(1, 1, 4'd1, 0);
    step(1, 1, 4'd3, 0);
    step(1, 1, 4'd0, 0);
    n_cmp++;
    if (disp !== 16'h0130 || timer_done !== 1'b0) begin
      n_err++; $display("FAIL entry_0130: got %h done=%b want 0130 done=0", disp, timer_done);
    end
    step(1, 1, 4'd12, 0);
    n_cmp++;
    if (disp !== 16'h0130) begin
      n_err++; $display("FAIL entry_bad_digit: got %h want 0130", disp);
    end
  endtask

  task automatic test_countdown();
    step(0, 0, 4'd0, 0);
    load_time(2);
    for (int c = 1; c <= 8; c++) begin
      step(1, 0, 4'd0, 1);
      n_cmp++;
      if ({disp, timer_done, running, beep} !== {exp_disp(), m_done, m_run, exp_beep()}) begin
        n_err++;
        $display("FAIL countdown_c%0d: got %h/%b%b%b want %h/%b%b%b", c, disp, timer_done,
                 running, beep, exp_disp(), m_done, m_run, exp_beep());
      end
      if (c == 4) begin
        n_cmp++;
        if (disp !== 16'h0001 || timer_done !== 1'b0) begin
          n_err++; $display("FAIL countdown_01: got %h done=%b want 0001 done=0", disp, timer_done);
        end
      end
      if (c == 8) begin
        n_cmp++;
        if (disp !== 16'h0000 || timer_done !== 1'b1 || running !== 1'b0) begin
          n_err++;
          $display("FAIL countdown_00: got %h done=%b run=%b want 0000 done=1 run=0",
                   disp, timer_done, running);
        end
      end
    end
  endtask

  task automatic test_borrow();
    int vals [4] = '{100, 10, 90, 1000};
    logic [15:0] want [4] = '{16'h0059, 16'h0009, 16'h0089, 16'h0959};
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 4'd0, 0);
      load_time(vals[i]);
      repeat (TICK) step(1, 0, 4'd0, 1);
      n_cmp++;
      if (disp !== want[i] || disp !== exp_disp()) begin
        n_err++; $display("FAIL borrow_%0d: got %h want %h", vals[i], disp, want[i]);
      end
    end
  endtask

  task automatic test_pause();
    step(0, 0, 4'd0, 0);
    load_time(5);
    for (int c = 1; c <= 6; c++) step(1, (c % 2) == 1, 4'd7, 1);
    n_cmp++;
    if (disp !== 16'h0004 || running !== 1'b1) begin
      n_err++; $display("FAIL pause_before: got %h run=%b want 0004 run=1", disp, running);
    end
    repeat (10) step(1, 0, 4'd0, 0);
    n_cmp++;
    if (disp !== 16'h0004 || running !== 1'b0) begin
      n_err++; $display("FAIL pause_hold: got %h run=%b want 0004 run=0", disp, running);
    end
    step(1, 0, 4'd0, 1);
    n_cmp++;
    if (disp !== 16'h0004 || running !== 1'b1) begin
      n_err++; $display("FAIL resume_1: got %h run=%b want 0004 run=1", disp, running);
    end
    step(1, 0, 4'd0, 1);
    n_cmp++;
    if (disp !== 16'h0003 || disp !== exp_disp()) begin
      n_err++; $display("FAIL resume_2: got %h want 0003", disp);
    end
  endtask

  task automatic test_idle_start();
    step(0, 0, 4'd0, 0);
    step(1, 0, 4'd0, 1);
    n_cmp++;
    if (timer_done !== 1'b1 || disp !== 16'h0000 || running !== 1'b0) begin
      n_err++; $display("FAIL idle_start: got done=%b %h run=%b want done=1 0000 run=0",
                        timer_done, disp, running);
    end
    step(1, 1, 4'd3, 1);
    n_cmp++;
    if (timer_done !== 1'b1 || disp !== 16'h0000) begin
      n_err++; $display("FAIL done_hold: got done=%b %h want done=1 0000", timer_done, disp);
    end
    step(0, 0, 4'd0, 0);
    n_cmp++;
    if (timer_done !== 1'b0 || disp !== 16'h0000) begin
      n_err++; $display("FAIL clear_done: got done=%b %h want done=0 0000", timer_done, disp);
    end
    step(1, 0, 4'd0, 1);
    step(1, 1, 4'd7, 0);
    n_cmp++;
    if (timer_done !== 1'b0 || disp !== 16'h0007) begin
      n_err++; $display("FAIL done_key: got done=%b %h want done=0 0007", timer_done, disp);
    end
  endtask

  task automatic test_random();
    bit mg;
    mg = 0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) mg = ~mg;
      step($urandom_range(0, 59) != 0, $urandom_range(0, 2) == 0,
           4'($urandom_range(0, 15)), mg);
      n_cmp++;
      if ({disp, timer_done, running, beep} !== {exp_disp(), m_done, m_run, exp_beep()}) begin
        n_err++;
        $display("FAIL random_c%0d: got %h/%b%b%b want %h/%b%b%b", c, disp, timer_done,
                 running, beep, exp_disp(), m_done, m_run, exp_beep());
      end
    end
  endtask

`ifdef TIMER_MAG_BEEP_EN
  task automatic test_beep();
    step(0, 0, 4'd0, 0);
    load_time(1);
    for (int c = 1; c <= 12; c++) begin
      step(1, 0, 4'd0, 1);
      n_cmp++;
      if (beep !== ((c >= TICK) && (c < TICK + BEEP)) || beep !== exp_beep()) begin
        n_err++; $display("FAIL beep_c%0d: got %b model %b", c, beep, exp_beep());
      end
    end
    step(0, 0, 4'd0, 0);
    load_time(1);
    repeat (TICK + 2) step(1, 0, 4'd0, 1);
    n_cmp++;
    if (beep !== 1'b1) begin
      n_err++; $display("FAIL beep_mid: got %b want 1", beep);
    end
    resetn = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (beep !== 1'b0 || timer_done !== 1'b0 || disp !== 16'h0000) begin
      n_err++; $display("FAIL beep_async_reset: got beep=%b done=%b %h want 0 0 0000",
                        beep, timer_done, disp);
    end
    #1;
    resetn = 1'b1;
    mag_on = 1'b0;
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_entry();
    test_countdown();
    test_borrow();
    test_pause();
    test_idle_start();
    test_random();
`ifdef TIMER_MAG_BEEP_EN
    test_beep();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
